// File: rtl/pc_gen_unit.sv
// Fetch-stage program-counter generator: prioritised redirects, halt, misalign flag.
// Optional return-address stack enabled by defining PCG_RAS_EN.
module pc_gen_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned     STEP      = 4,
  parameter int unsigned     NUM_REDIR = 3,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic                      PCG_CLK,
  input  logic                      PCG_RST,
  input  logic [NUM_REDIR-1:0]      PCG_REDIR_VLD,
  input  logic [NUM_REDIR*XLEN-1:0] PCG_REDIR_TGT,
  input  logic                      PCG_HALT,
  input  logic                      PCG_OUT_RDY,
  output logic                      PCG_OUT_VLD,
  output logic [XLEN-1:0]           PCG_OUT,
  output logic                      PCG_HALTED,
  output logic                      PCG_MISALIGN,
  input  logic                      PCG_RAS_PUSH,
  input  logic [XLEN-1:0]           PCG_RAS_ADDR,
  input  logic                      PCG_RAS_POP,
  output logic                      PCG_RAS_UFLOW
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);
  localparam logic [XLEN-1:0] STEP_INC   = XLEN'(STEP);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            vld_q, vld_d;
  logic            halted_q, halted_d;
  logic            mis_q, mis_d;
  logic            active;
  logic            redir_any;
  logic [XLEN-1:0] redir_tgt;
  logic            ras_pop_hit;
  logic [XLEN-1:0] ras_top;

  assign active = (state_q != ST_BOOT);

  // Lowest-index valid redirect source wins
  always_comb begin
    redir_any = 1'b0;
    redir_tgt = '0;
    for (int unsigned i = 0; i < NUM_REDIR; i++) begin
      if (PCG_REDIR_VLD[i] && !redir_any) begin
        redir_any = 1'b1;
        redir_tgt = PCG_REDIR_TGT[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mis_d   = 1'b0;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (PCG_HALT)  state_d = ST_HALT;
      ST_HALT: if (!PCG_HALT) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
    if (active) begin
      if (redir_any) begin
        pc_d  = redir_tgt & ~ALIGN_MASK;
        mis_d = |(redir_tgt & ALIGN_MASK);
      end else if (ras_pop_hit) begin
        pc_d = ras_top;
      end else if (state_q == ST_RUN && vld_q && PCG_OUT_RDY) begin
        pc_d = pc_q + STEP_INC;
      end
    end
    vld_d    = (state_d == ST_RUN);
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge PCG_CLK or posedge PCG_RST) begin
    if (PCG_RST) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_VEC;
      vld_q    <= 1'b0;
      halted_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      vld_q    <= vld_d;
      halted_q <= halted_d;
      mis_q    <= mis_d;
    end
  end

  assign PCG_OUT      = pc_q;
  assign PCG_OUT_VLD  = vld_q;
  assign PCG_HALTED   = halted_q;
  assign PCG_MISALIGN = mis_q;

`ifdef PCG_RAS_EN
  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d, wr_idx;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_en;
  logic            uflow_q, uflow_d;

  // ptr_q addresses the top entry; pushing past full wraps onto the oldest slot
  always_comb begin
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    wr_en       = 1'b0;
    wr_idx      = ptr_q;
    uflow_d     = 1'b0;
    ras_pop_hit = active && PCG_RAS_POP && (cnt_q != '0);
    ras_top     = ras_q[ptr_q];
    if (active) begin
      if (PCG_RAS_PUSH && ras_pop_hit) begin
        wr_en = 1'b1;
      end else if (PCG_RAS_PUSH) begin
        wr_en  = 1'b1;
        ptr_d  = ptr_q + PW'(1);
        wr_idx = ptr_q + PW'(1);
        if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + CW'(1);
      end else if (ras_pop_hit) begin
        ptr_d = ptr_q - PW'(1);
        cnt_d = cnt_q - CW'(1);
      end
      uflow_d = PCG_RAS_POP && (cnt_q == '0);
    end
  end

  always_ff @(posedge PCG_CLK or posedge PCG_RST) begin
    if (PCG_RST) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      uflow_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      uflow_q <= uflow_d;
    end
  end

  always_ff @(posedge PCG_CLK) begin
    if (wr_en) ras_q[wr_idx] <= PCG_RAS_ADDR;
  end

  assign PCG_RAS_UFLOW = uflow_q;
`else
  logic unused_ras;
  assign unused_ras    = (^{PCG_RAS_PUSH, PCG_RAS_POP, PCG_RAS_ADDR}) ^ (RAS_DEPTH == 0);
  assign ras_pop_hit   = 1'b0;
  assign ras_top       = '0;
  assign PCG_RAS_UFLOW = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen_unit.sv
// Vector-table bench for pc_gen_unit with an expected-result queue.
// Covers both builds; RAS-only vectors are included when PCG_RAS_EN is defined.
module tb_pc_gen_unit;

  localparam int unsigned XLEN = 32;
`ifdef PCG_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic            clk, rst;
  logic [2:0]      redir_vld;
  logic [3*32-1:0] redir_tgt;
  logic            halt, rdy, push, pop;
  logic [31:0]     ras_addr;
  logic            out_vld, halted, mis, uf;
  logic [31:0]     out_pc;

  pc_gen_unit #(.XLEN(32), .RESET_VEC(32'h0), .STEP(4), .NUM_REDIR(3), .RAS_DEPTH(4)) dut (
    .PCG_CLK(clk), .PCG_RST(rst),
    .PCG_REDIR_VLD(redir_vld), .PCG_REDIR_TGT(redir_tgt),
    .PCG_HALT(halt), .PCG_OUT_RDY(rdy),
    .PCG_OUT_VLD(out_vld), .PCG_OUT(out_pc), .PCG_HALTED(halted), .PCG_MISALIGN(mis),
    .PCG_RAS_PUSH(push), .PCG_RAS_ADDR(ras_addr), .PCG_RAS_POP(pop), .PCG_RAS_UFLOW(uf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  rv;
    logic [31:0] t0, t1, t2;
    logic        h, r, pu, po;
    logic [31:0] ra;
    logic        e_vld;
    logic [31:0] e_pc;
    logic        e_halted, e_mis, e_uf;
  } vec_t;

  typedef struct {
    string       name;
    logic        e_vld;
    logic [31:0] e_pc;
    logic        e_halted, e_mis, e_uf;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(string name, logic [2:0] rv, logic [31:0] t0, logic [31:0] t1,
                              logic [31:0] t2, logic h, logic r, logic pu, logic po,
                              logic [31:0] ra, logic ev, logic [31:0] ep, logic eh,
                              logic em, logic eu);
    vec_t v;
    v.name = name; v.rv = rv; v.t0 = t0; v.t1 = t1; v.t2 = t2;
    v.h = h; v.r = r; v.pu = pu; v.po = po; v.ra = ra;
    v.e_vld = ev; v.e_pc = ep; v.e_halted = eh; v.e_mis = em; v.e_uf = eu;
    return v;
  endfunction

  task automatic chk(string nm, string fld, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  task automatic check_outs(string nm, logic ev, logic [31:0] ep, logic eh, logic em, logic eu);
    chk(nm, "vld",      32'(out_vld), 32'(ev));
    chk(nm, "pc",       out_pc,       ep);
    chk(nm, "halted",   32'(halted),  32'(eh));
    chk(nm, "misalign", 32'(mis),     32'(em));
    chk(nm, "uflow",    32'(uf),      32'(eu));
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    redir_vld = v.rv;
    redir_tgt = {v.t2, v.t1, v.t0};
    halt      = v.h;
    rdy       = v.r;
    push      = v.pu;
    pop       = v.po;
    ras_addr  = v.ra;
    exp_q.push_back('{name: v.name, e_vld: v.e_vld, e_pc: v.e_pc,
                      e_halted: v.e_halted, e_mis: v.e_mis, e_uf: v.e_uf});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk(v.name, "scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_outs(e.name, e.e_vld, e.e_pc, e.e_halted, e.e_mis, e.e_uf);
    end
  endtask

  initial begin
    rst = 1'b1; redir_vld = '0; redir_tgt = '0; halt = 1'b0; rdy = 1'b1;
    push = 1'b0; pop = 1'b0; ras_addr = '0;

    //        name         rv      t0            t1            t2            h  r  pu po ra        vld pc            hl mis uf
    vecs.push_back(mk("boot",     3'b000, 0,            0,            0,            0, 1, 0, 0, 0,        1, 32'h0,         0, 0, 0));
    vecs.push_back(mk("seq4",     3'b000, 0,            0,            0,            0, 1, 0, 0, 0,        1, 32'h4,         0, 0, 0));
    vecs.push_back(mk("seq8",     3'b000, 0,            0,            0,            0, 1, 0, 0, 0,        1, 32'h8,         0, 0, 0));
    vecs.push_back(mk("seqc",     3'b000, 0,            0,            0,            0, 1, 0, 0, 0,        1, 32'hC,         0, 0, 0));
    vecs.push_back(mk("seq10",    3'b000, 0,            0,            0,            0, 1, 0, 0, 0,        1, 32'h10,        0, 0, 0));
    vecs.push_back(mk("stall1",   3'b000, 0,            0,            0,            0, 0, 0, 0, 0,        1, 32'h10,        0, 0, 0));
    vecs.push_back(mk("stall2",   3'b000, 0,            0,            0,            0, 0, 0, 0, 0,        1, 32'h10,        0, 0, 0));
    vecs.push_back(mk("stall3",   3'b000, 0,            0,            0,            0, 0, 0, 0, 0,        1, 32'h10,        0, 0, 0));
    vecs.push_back(mk("unstall",  3'b000, 0,            0,            0,            0, 1, 0, 0, 0,        1, 32'h14,        0, 0, 0));
    vecs.push_back(mk("prio12",   3'b110, 0,            32'h100,      32'h200,      0, 1, 0, 0, 0,        1, 32'h100,       0, 0, 0));
    vecs.push_back(mk("after12",  3'b000, 0,            0,            0,            0, 1, 0, 0, 0,        1, 32'h104,       0, 0, 0));
    vecs.push_back(mk("misal0",   3'b001, 32'h203,      0,            0,            0, 1, 0, 0, 0,        1, 32'h200,       0, 1, 0));
    vecs.push_back(mk("misclr",   3'b000, 0,            0,            0,            0, 1, 0, 0, 0,        1, 32'h204,       0, 0, 0));
    vecs.push_back(mk("loserodd", 3'b011, 32'h300,      32'h305,      0,            0, 1, 0, 0, 0,        1, 32'h300,       0, 0, 0));
    vecs.push_back(mk("redir_nr", 3'b100, 0,            0,            32'h400,      0, 0, 0, 0, 0,        1, 32'h400,       0, 0, 0));
    vecs.push_back(mk("hold400",  3'b000, 0,            0,            0,            0, 0, 0, 0, 0,        1, 32'h400,       0, 0, 0));
    vecs.push_back(mk("to_top",   3'b001, 32'hFFFF_FFFC, 0,           0,            0, 1, 0, 0, 0,        1, 32'hFFFF_FFFC, 0, 0, 0));
    vecs.push_back(mk("wrap",     3'b000, 0,            0,            0,            0, 1, 0, 0, 0,        1, 32'h0,         0, 0, 0));
    vecs.push_back(mk("halt_in",  3'b000, 0,            0,            0,            1, 0, 0, 0, 0,        0, 32'h0,         1, 0, 0));
    vecs.push_back(mk("halt_rdy", 3'b000, 0,            0,            0,            1, 1, 0, 0, 0,        0, 32'h0,         1, 0, 0));
    vecs.push_back(mk("halt_red", 3'b001, 32'h40,       0,            0,            1, 1, 0, 0, 0,        0, 32'h40,        1, 0, 0));
    vecs.push_back(mk("resume",   3'b000, 0,            0,            0,            0, 1, 0, 0, 0,        1, 32'h40,        0, 0, 0));
    vecs.push_back(mk("run44",    3'b000, 0,            0,            0,            0, 1, 0, 0, 0,        1, 32'h44,        0, 0, 0));
    vecs.push_back(mk("halt+red", 3'b010, 0,            32'h81,       0,            1, 1, 0, 0, 0,        0, 32'h80,        1, 1, 0));
    vecs.push_back(mk("resume80", 3'b000, 0,            0,            0,            0, 0, 0, 0, 0,        1, 32'h80,        0, 0, 0));
    vecs.push_back(mk("pop_mt",   3'b000, 0,            0,            0,            0, 1, 0, 1, 0,        1, 32'h84,        0, 0, RAS_ON));
    vecs.push_back(mk("push_a0",  3'b000, 0,            0,            0,            0, 0, 1, 0, 32'hA0,   1, 32'h84,        0, 0, 0));
    vecs.push_back(mk("pop_a0",   3'b000, 0,            0,            0,            0, 0, 0, 1, 0,        1, RAS_ON ? 32'hA0 : 32'h84, 0, 0, 0));
    vecs.push_back(mk("seq_pa",   3'b000, 0,            0,            0,            0, 1, 0, 0, 0,        1, RAS_ON ? 32'hA4 : 32'h88, 0, 0, 0));
`ifdef PCG_RAS_EN
    vecs.push_back(mk("push1",    3'b000, 0, 0, 0, 0, 0, 1, 0, 32'hA0,  1, 32'hA4,  0, 0, 0));
    vecs.push_back(mk("push2",    3'b000, 0, 0, 0, 0, 0, 1, 0, 32'hB0,  1, 32'hA4,  0, 0, 0));
    vecs.push_back(mk("push3",    3'b000, 0, 0, 0, 0, 0, 1, 0, 32'hC0,  1, 32'hA4,  0, 0, 0));
    vecs.push_back(mk("push4",    3'b000, 0, 0, 0, 0, 0, 1, 0, 32'hD0,  1, 32'hA4,  0, 0, 0));
    vecs.push_back(mk("push5",    3'b000, 0, 0, 0, 0, 0, 1, 0, 32'hE0,  1, 32'hA4,  0, 0, 0));
    vecs.push_back(mk("pop_e0",   3'b000, 0, 0, 0, 0, 0, 0, 1, 0,       1, 32'hE0,  0, 0, 0));
    vecs.push_back(mk("pop_d0",   3'b000, 0, 0, 0, 0, 0, 0, 1, 0,       1, 32'hD0,  0, 0, 0));
    vecs.push_back(mk("pop_c0",   3'b000, 0, 0, 0, 0, 0, 0, 1, 0,       1, 32'hC0,  0, 0, 0));
    vecs.push_back(mk("pop_b0",   3'b000, 0, 0, 0, 0, 0, 0, 1, 0,       1, 32'hB0,  0, 0, 0));
    vecs.push_back(mk("pop_uf",   3'b000, 0, 0, 0, 0, 1, 0, 1, 0,       1, 32'hB4,  0, 0, 1));
    vecs.push_back(mk("uf_clr",   3'b000, 0, 0, 0, 0, 0, 0, 0, 0,       1, 32'hB4,  0, 0, 0));
    vecs.push_back(mk("push_f0",  3'b000, 0, 0, 0, 0, 0, 1, 0, 32'hF0,  1, 32'hB4,  0, 0, 0));
    vecs.push_back(mk("pushpop",  3'b000, 0, 0, 0, 0, 0, 1, 1, 32'h120, 1, 32'hF0,  0, 0, 0));
    vecs.push_back(mk("pop_120",  3'b000, 0, 0, 0, 0, 0, 0, 1, 0,       1, 32'h120, 0, 0, 0));
    vecs.push_back(mk("pop_uf2",  3'b000, 0, 0, 0, 0, 0, 0, 1, 0,       1, 32'h120, 0, 0, 1));
    vecs.push_back(mk("push_150", 3'b000, 0, 0, 0, 0, 0, 1, 0, 32'h150, 1, 32'h120, 0, 0, 0));
    vecs.push_back(mk("pop_lose", 3'b001, 32'h500, 0, 0, 0, 0, 0, 1, 0, 1, 32'h500, 0, 0, 0));
    vecs.push_back(mk("pop_uf3",  3'b000, 0, 0, 0, 0, 0, 0, 1, 0,       1, 32'h500, 0, 0, 1));
`endif

    #12;
    check_outs("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Async reset mid-stream with a pending misalign pulse and a non-empty RAS
    step(mk("pre_rst", 3'b001, 32'h703, 0, 0, 0, 1, 1, 0, 32'h60, 1, 32'h700, 0, 1, 0));
    redir_vld = '0; push = 1'b0; pop = 1'b0; rdy = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    check_outs("async_rst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    step(mk("reboot",   3'b000, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h0, 0, 0, 0));
    step(mk("post_pop", 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h0, 0, 0, RAS_ON));
    step(mk("post_seq", 3'b000, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h4, 0, 0, 0));

    if (exp_q.size() != 0) chk("end", "scoreboard_left", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
